// File: rtl/ps2_pkg.sv
// Shared constants, frame FSM state type and helper functions for the
// PS/2 game-key receiver.
package ps2_pkg;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  localparam logic [7:0] KEY_LEFT_EXT  = 8'h6B;
  localparam logic [7:0] KEY_LEFT_STD  = 8'h1C;
  localparam logic [7:0] KEY_RIGHT_EXT = 8'h74;
  localparam logic [7:0] KEY_RIGHT_STD = 8'h23;
  localparam logic [7:0] KEY_UP_EXT    = 8'h75;
  localparam logic [7:0] KEY_UP_STD    = 8'h1D;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STOP  = 2'd2
  } frame_state_t;

  typedef struct packed {
    logic up;
    logic right;
    logic left;
  } key_vec_t;

  // Odd parity over data plus parity bit: a good frame has an odd count of ones.
  function automatic logic parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

  // Extended codes only match extended entries and plain codes only plain ones.
  function automatic key_vec_t key_lookup(input logic [7:0] code, input logic ext);
    key_vec_t v;
    v = '0;
    if (ext) begin
      case (code)
        KEY_LEFT_EXT:  v.left  = 1'b1;
        KEY_RIGHT_EXT: v.right = 1'b1;
        KEY_UP_EXT:    v.up    = 1'b1;
        default:       v       = '0;
      endcase
    end else begin
      case (code)
        KEY_LEFT_STD:  v.left  = 1'b1;
        KEY_RIGHT_STD: v.right = 1'b1;
        KEY_UP_STD:    v.up    = 1'b1;
        default:       v       = '0;
      endcase
    end
    return v;
  endfunction

endpackage

// File: rtl/ps2_game_keys_if.sv
// Bundle of the raw PS/2 lines and the decoded key/scan-code outputs.
interface ps2_game_keys_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scan_code;
  logic       code_valid;
  logic       frame_err;
  logic       key_left;
  logic       key_right;
  logic       key_up;
  logic       press_left;
  logic       press_right;
  logic       press_up;

  modport slave (
    input  ps2_clk, ps2_data,
    output scan_code, code_valid, frame_err,
    output key_left, key_right, key_up,
    output press_left, press_right, press_up
  );

  modport master (
    output ps2_clk, ps2_data,
    input  scan_code, code_valid, frame_err,
    input  key_left, key_right, key_up,
    input  press_left, press_right, press_up
  );
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 byte receiver: synchronizers, clock glitch filter, 11-bit frame FSM
// with mid-frame timeout; emits validated bytes or an error pulse.
module ps2_rx_frame #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       frame_err
);
  import ps2_pkg::*;

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic          clk_meta_r, clk_sync_r;
  logic          data_meta_r, data_sync_r;
  logic          filt_r, filt_d_r;
  logic [FW-1:0] filt_cnt_r;
  logic          fall_s;
  logic          timeout_s;

  frame_state_t  state_r;
  logic [3:0]    bit_cnt_r;
  logic [8:0]    shift_r;
  logic [TW-1:0] tmo_cnt_r;
  logic [7:0]    scan_code_r;
  logic          code_valid_r;
  logic          frame_err_r;

  assign fall_s    = filt_d_r & ~filt_r;
  assign timeout_s = (tmo_cnt_r == TW'(TIMEOUT));

  // Synchronize both lines; filtered clock flips only after FILTER_LEN agreeing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
      filt_r      <= 1'b1;
      filt_d_r    <= 1'b1;
      filt_cnt_r  <= '0;
    end else begin
      clk_meta_r  <= ps2_clk;
      clk_sync_r  <= clk_meta_r;
      data_meta_r <= ps2_data;
      data_sync_r <= data_meta_r;
      filt_d_r    <= filt_r;
      if (clk_sync_r == filt_r) begin
        filt_cnt_r <= '0;
      end else if (filt_cnt_r == FW'(FILTER_LEN - 1)) begin
        filt_r     <= clk_sync_r;
        filt_cnt_r <= '0;
      end else begin
        filt_cnt_r <= filt_cnt_r + FW'(1);
      end
    end
  end

  // Frame FSM: start bit, 9 shifted bits (LSB first), then stop-bit validation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      bit_cnt_r    <= 4'd0;
      shift_r      <= 9'd0;
      tmo_cnt_r    <= '0;
      scan_code_r  <= 8'h00;
      code_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      code_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      if (fall_s) begin
        tmo_cnt_r <= '0;
      end else if (state_r != IDLE) begin
        tmo_cnt_r <= tmo_cnt_r + TW'(1);
      end else begin
        tmo_cnt_r <= '0;
      end

      case (state_r)
        IDLE: begin
          if (fall_s && !data_sync_r) begin
            state_r   <= SHIFT;
            bit_cnt_r <= 4'd0;
          end
        end
        SHIFT: begin
          if (fall_s) begin
            shift_r   <= {data_sync_r, shift_r[8:1]};
            bit_cnt_r <= bit_cnt_r + 4'd1;
            if (bit_cnt_r == 4'd8) begin
              state_r <= STOP;
            end
          end else if (timeout_s) begin
            frame_err_r <= 1'b1;
            state_r     <= IDLE;
          end
        end
        STOP: begin
          if (fall_s) begin
            if (data_sync_r && parity_ok(shift_r)) begin
              scan_code_r  <= shift_r[7:0];
              code_valid_r <= 1'b1;
            end else begin
              frame_err_r <= 1'b1;
            end
            state_r <= IDLE;
          end else if (timeout_s) begin
            frame_err_r <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign scan_code  = scan_code_r;
  assign code_valid = code_valid_r;
  assign frame_err  = frame_err_r;

endmodule

// File: rtl/ps2_game_keys.sv
// PS/2 keyboard front end for the game: tracks E0/F0 prefixes and turns
// left/right/up scan codes into held levels and make pulses.
module ps2_game_keys #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 20000
) (
  input  logic            clk,
  input  logic            reset,
  ps2_game_keys_if.slave  bus
);
  import ps2_pkg::*;

  logic [7:0] scan_code_s;
  logic       code_valid_s;
  logic       frame_err_s;
  key_vec_t   hit_s;
  key_vec_t   level_r;
  key_vec_t   press_r;
  logic       ext_r;
  logic       brk_r;

  ps2_rx_frame #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT    (TIMEOUT)
  ) u_rx (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (bus.ps2_clk),
    .ps2_data   (bus.ps2_data),
    .scan_code  (scan_code_s),
    .code_valid (code_valid_s),
    .frame_err  (frame_err_s)
  );

  // Map the current byte to a key under the pending extended prefix.
  always_comb begin
    hit_s = key_lookup(scan_code_s, ext_r);
  end

  // Prefix flags and key levels; typematic repeats of a held key do not pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      ext_r   <= 1'b0;
      brk_r   <= 1'b0;
      level_r <= '0;
      press_r <= '0;
    end else begin
      press_r <= '0;
      if (code_valid_s) begin
        if (scan_code_s == SC_EXT) begin
          ext_r <= 1'b1;
        end else if (scan_code_s == SC_BRK) begin
          brk_r <= 1'b1;
        end else begin
          if (brk_r) begin
            level_r <= key_vec_t'(level_r & ~hit_s);
          end else begin
            level_r <= key_vec_t'(level_r | hit_s);
            press_r <= key_vec_t'(hit_s & ~level_r);
          end
          ext_r <= 1'b0;
          brk_r <= 1'b0;
        end
      end else if (frame_err_s) begin
        ext_r <= 1'b0;
        brk_r <= 1'b0;
      end
    end
  end

  assign bus.scan_code   = scan_code_s;
  assign bus.code_valid  = code_valid_s;
  assign bus.frame_err   = frame_err_s;
  assign bus.key_left    = level_r.left;
  assign bus.key_right   = level_r.right;
  assign bus.key_up      = level_r.up;
  assign bus.press_left  = press_r.left;
  assign bus.press_right = press_r.right;
  assign bus.press_up    = press_r.up;

endmodule
